rr_mux4_arbiter: RTL and testbench

Round-robin arbiter that shares one 4:1 mux output channel between four requesters. It registers the mux select and a one-hot grant, and holds a grant until the owner drops its request or a hold limit expires. It sits in front of the mux4to1 datapath family, so downstream logic sees one qualified data stream (out, out_valid).

---
 rtl/rr_mux4_arbiter_pkg.sv | 25 ++
 rtl/rr_pick4.sv | 32 +++
 rtl/rr_mux4_arbiter.sv | 132 +++++++++++++
 tb/tb_rr_mux4_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/rr_mux4_arbiter_pkg.sv
// rtl/rr_mux4_arbiter_pkg.sv - shared types and constants for the 4-way round-robin arbiter
//
// Contents:
//   state_t   arbiter FSM state (IDLE, GRANT)
//   NUM_REQ   number of requesters (4)
//   SEL_W     width of a requester index (2)
//   onehot()  index -> one-hot grant vector
package rr_mux4_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - circular first-set-bit search over a 4-bit mask
//
// Ports:
//   mask   in   4  candidate requesters
//   ptr    in   2  index with highest priority; search wraps 3 -> 0
//   found  out  1  mask has at least one bit set
//   idx    out  2  first set bit at or after ptr (ptr when nothing found)
module rr_pick4
  import rr_mux4_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] mask,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  always_comb begin
    logic [SEL_W-1:0] cand;
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      // 2-bit addition wraps naturally, giving the circular order
      cand = ptr + SEL_W'(k);
      if (!found && mask[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// rtl/rr_mux4_arbiter.sv - round-robin arbiter sharing one 4:1 data channel
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   req        in   4      request vector, bit i = requester i
//   in0..in3   in   WIDTH  requester data
//   sel        out  2      registered index of current owner (held while idle)
//   gnt        out  4      registered one-hot grant, 0000 when idle
//   out        out  WIDTH  in[sel] while out_valid, else 0
//   out_valid  out  1      grant active
module rr_mux4_arbiter
  import rr_mux4_arbiter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [WIDTH-1:0]   in0,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic [WIDTH-1:0]   in3,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_REQ-1:0] gnt,
  output logic [WIDTH-1:0]   out,
  output logic               out_valid
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  state_t             state, state_n;
  logic [SEL_W-1:0]   ptr, ptr_n;
  logic [HOLD_W-1:0]  hold_cnt, hold_n;
  logic [SEL_W-1:0]   sel_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic               out_valid_n;

  logic [NUM_REQ-1:0] pick_mask;
  logic [SEL_W-1:0]   pick_ptr;
  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic [WIDTH-1:0]   mux_data;

  // One picker serves both paths: from IDLE it searches all requests from
  // ptr; during a grant it searches the other requesters starting just past
  // the owner, which is where ptr is heading on a release anyway.
  assign pick_mask = (state == IDLE) ? req : (req & ~gnt);
  assign pick_ptr  = (state == IDLE) ? ptr : (sel + SEL_W'(1));

  rr_pick4 u_pick (
    .mask  (pick_mask),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      sel       <= '0;
      gnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      hold_cnt  <= hold_n;
      sel       <= sel_n;
      gnt       <= gnt_n;
      out_valid <= out_valid_n;
    end
  end

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    hold_n      = hold_cnt;
    sel_n       = sel;
    gnt_n       = gnt;
    out_valid_n = out_valid;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_n     = GRANT;
          sel_n       = pick_idx;
          gnt_n       = onehot(pick_idx);
          out_valid_n = 1'b1;
          hold_n      = HOLD_ONE;
        end
      end
      GRANT: begin
        if (req[sel] && (hold_cnt < HOLD_MAX)) begin
          hold_n = hold_cnt + HOLD_ONE;
        end else begin
          // Voluntary or forced release: priority moves past the owner.
          ptr_n = sel + SEL_W'(1);
          if (pick_found) begin
            sel_n  = pick_idx;
            gnt_n  = onehot(pick_idx);
            hold_n = HOLD_ONE;
          end else if (req[sel]) begin
            // Hold limit hit with nobody waiting: owner keeps the channel.
            hold_n = HOLD_ONE;
          end else begin
            state_n     = IDLE;
            gnt_n       = '0;
            out_valid_n = 1'b0;
            hold_n      = '0;
          end
        end
      end
    endcase
  end

  always_comb begin
    mux_data = '0;
    case (sel)
      2'd0: mux_data = in0;
      2'd1: mux_data = in1;
      2'd2: mux_data = in2;
      2'd3: mux_data = in3;
    endcase
  end

  assign out = out_valid ? mux_data : '0;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// tb/tb_rr_mux4_arbiter.sv - self-checking bench for rr_mux4_arbiter
module tb_rr_mux4_arbiter;

  localparam int W  = 8;
  localparam int MH = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [W-1:0] in0, in1, in2, in3;
  logic [1:0]   sel;
  logic [3:0]   gnt;
  logic [W-1:0] out;
  logic         out_valid;

  int n_pass  = 0;
  int n_total = 0;

  // reference model: owner index (-1 = idle), priority pointer, hold count
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  int m_sel   = 0;

  rr_mux4_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .sel       (sel),
    .gnt       (gnt),
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int pick(input logic [3:0] m, input int p);
    for (int k = 0; k < 4; k++) begin
      if (m[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_edge();
    logic [3:0] others;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_hold = 0; m_sel = 0;
    end else if (m_owner < 0) begin
      if (req != 4'b0000) begin
        m_owner = pick(req, m_ptr);
        m_sel   = m_owner;
        m_hold  = 1;
      end
    end else if (req[m_owner] && m_hold < MH) begin
      m_hold = m_hold + 1;
    end else begin
      m_ptr  = (m_owner + 1) % 4;
      others = req;
      others[m_owner] = 1'b0;
      if (others != 4'b0000) begin
        m_owner = pick(others, m_ptr);
        m_sel   = m_owner;
        m_hold  = 1;
      end else if (req[m_owner]) begin
        m_hold = 1;
      end else begin
        m_owner = -1;
        m_hold  = 0;
      end
    end
  endtask

  task automatic check_model();
    logic [3:0]   eg;
    logic [W-1:0] ed;
    eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    case (m_sel)
      0: ed = in0;
      1: ed = in1;
      2: ed = in2;
      default: ed = in3;
    endcase
    if (m_owner < 0) ed = '0;
    check("gnt",       32'(gnt),          32'(eg));
    check("sel",       32'(sel),          32'(m_sel));
    check("out_valid", 32'(out_valid),    32'(m_owner >= 0));
    check("out",       32'(out),          32'(ed));
    check("hold_cnt",  32'(dut.hold_cnt), 32'(m_hold));
  endtask

  // one clock: model follows the edge, outputs compared on the falling edge
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  initial begin
    rst = 1'b1; req = 4'b1111;
    in0 = 8'h10; in1 = 8'h21; in2 = 8'h32; in3 = 8'h43;

    // 1: reset with all requests pending, then first grant to requester 0
    cycle(); cycle();
    check("t1_rst_gnt", 32'(gnt), 32'h0);
    check("t1_rst_out", 32'(out), 32'h0);
    rst = 1'b0;
    cycle();
    check("t1_first_gnt", 32'(gnt), 32'h1);
    check("t1_first_sel", 32'(sel), 32'h0);

    // 2: single requester, data passthrough, drop to idle
    req = 4'b0000; cycle();
    req = 4'b0100; in2 = 8'hA5; cycle();
    check("t2_gnt", 32'(gnt), 32'h4);
    check("t2_sel", 32'(sel), 32'h2);
    check("t2_out", 32'(out), 32'hA5);
    req = 4'b0000; cycle();
    check("t2_idle_gnt", 32'(gnt), 32'h0);
    check("t2_idle_out", 32'(out), 32'h0);

    // 3: all requesting, each owner held exactly MH cycles in rotation
    rst = 1'b1; cycle();
    rst = 1'b0; req = 4'b1111;
    for (int c = 0; c < 5 * MH; c++) begin
      cycle();
      check("t3_seq", 32'(gnt), 32'(4'b0001 << ((c / MH) % 4)));
      check("t3_valid", 32'(out_valid), 32'h1);
    end

    // 4: voluntary release hands off directly; wrap from 3 back to 0
    rst = 1'b1; cycle();
    rst = 1'b0; req = 4'b1011;
    cycle(); cycle(); cycle();
    check("t4_owner0", 32'(gnt), 32'h1);
    req = 4'b1010; cycle();
    check("t4_to1", 32'(gnt), 32'h2);
    req = 4'b1001; cycle();
    check("t4_to3", 32'(gnt), 32'h8);
    req = 4'b0001; cycle();
    check("t4_wrap0", 32'(gnt), 32'h1);

    // 5: lone requester re-granted past the hold limit
    for (int c = 0; c < 20; c++) begin
      cycle();
      check("t5_gnt", 32'(gnt), 32'h1);
    end

    // 6: reset mid-grant, regrant one cycle after release of reset
    req = 4'b0100; cycle();
    check("t6_gnt2", 32'(gnt), 32'h4);
    cycle();
    rst = 1'b1; cycle();
    check("t6_rst", 32'(gnt), 32'h0);
    rst = 1'b0; cycle();
    check("t6_regrant", 32'(gnt), 32'h4);

    // random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      in0 = W'($urandom); in1 = W'($urandom);
      in2 = W'($urandom); in3 = W'($urandom);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 63) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
